// File: rtl/bram_wb_arb2.sv
// Block RAM shared by two Wishbone classic slave ports (A, B). A round-robin arbiter puts one request at a time on the array.
// Latency: the request is sampled at edge N, and ack_o is high from edge N+READ_LATENCY+1 for one cycle. Reads and writes take the same time.
// Backpressure: the port that is not granted keeps its request pending and is served next. There is always one idle cycle after each ack.
//
// Ports: wb_clock_i / wb_reset_i (async, active-high) are the clock and reset.
//        a_* / b_*: addr, data in/out, we, cycle, strobe, ack for each Wishbone slave port.
//        wp_i: write protect, sampled at grant. Protected writes are acked but not stored.
module bram_wb_arb2 #(
    parameter int DATA_WIDTH   = 8,
    parameter int DATA_DEPTH   = 1024,
    parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic [DATA_WIDTH-1:0] a_data_o,
    input  logic                  a_we_i,
    input  logic                  a_cycle_i,
    input  logic                  a_strobe_i,
    output logic                  a_ack_o,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic [DATA_WIDTH-1:0] b_data_o,
    input  logic                  b_we_i,
    input  logic                  b_cycle_i,
    input  logic                  b_strobe_i,
    output logic                  b_ack_o,
    input  logic                  wp_i
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = DATA_DEPTH[ADDR_WIDTH:0];
    localparam logic [1:0]          RL        = READ_LATENCY[1:0];

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                state;
    logic [1:0]            cnt;
    logic                  gnt_b;      // granted port: 1 = B
    logic                  last_b;     // last granted port: 1 = B
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic                  we_q;
    logic                  wp_q;
    logic                  abort_q;
    logic                  rd_zero;    // last access was out of range, so its read returns 0
    logic [DATA_WIDTH-1:0] rd_raw;
    logic [DATA_WIDTH-1:0] stage2;
    logic [DATA_WIDTH-1:0] stage3;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] final_word;

    logic [DATA_WIDTH-1:0] mem [0:DATA_DEPTH-1];

    logic a_req, b_req, pick_b, in_rng, acc, cur_cyc;

    assign a_req   = a_cycle_i & a_strobe_i;
    assign b_req   = b_cycle_i & b_strobe_i;
    // When both ports request, the port that was not granted last time wins.
    assign pick_b  = b_req & (~a_req | ~last_b);
    assign in_rng  = {1'b0, addr_q} < DEPTH_LIM;
    // The array is touched only on the first edge spent in WAIT.
    assign acc     = (state == WAIT) && (cnt == RL);
    assign cur_cyc = gnt_b ? b_cycle_i : a_cycle_i;

    assign rd_word    = rd_zero ? '0 : rd_raw;
    assign final_word = (READ_LATENCY == 1) ? rd_word :
                        (READ_LATENCY == 2) ? stage2  : stage3;

    // The array has no reset, so its contents survive wb_reset_i.
    always_ff @(posedge wb_clock_i) begin
        if (acc && in_rng) begin
            if (we_q && !wp_q)
                mem[addr_q] <= wdat_q;
            rd_raw <= mem[addr_q];
        end
    end

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt_b    <= 1'b0;
            last_b   <= 1'b1;
            addr_q   <= '0;
            wdat_q   <= '0;
            we_q     <= 1'b0;
            wp_q     <= 1'b0;
            abort_q  <= 1'b0;
            rd_zero  <= 1'b0;
            stage2   <= '0;
            stage3   <= '0;
            a_ack_o  <= 1'b0;
            b_ack_o  <= 1'b0;
            a_data_o <= '0;
            b_data_o <= '0;
        end else begin
            stage2  <= rd_word;
            stage3  <= stage2;
            a_ack_o <= 1'b0;
            b_ack_o <= 1'b0;
            if (acc)
                rd_zero <= ~in_rng;
            case (state)
                IDLE: begin
                    // While an ack is on the bus, the master still holds strobe.
                    // Skip that edge so the same request is not granted a second time.
                    if (!(a_ack_o || b_ack_o) && (a_req || b_req)) begin
                        gnt_b   <= pick_b;
                        last_b  <= pick_b;
                        addr_q  <= pick_b ? b_addr_i : a_addr_i;
                        wdat_q  <= pick_b ? b_data_i : a_data_i;
                        we_q    <= pick_b ? b_we_i   : a_we_i;
                        wp_q    <= wp_i;
                        abort_q <= 1'b0;
                        cnt     <= RL;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!cur_cyc)
                        abort_q <= 1'b1;
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1)
                        state <= ACK;
                end
                ACK: begin
                    if (!abort_q) begin
                        if (gnt_b) begin
                            b_ack_o <= 1'b1;
                            if (!we_q)
                                b_data_o <= final_word;
                        end else begin
                            a_ack_o <= 1'b1;
                            if (!we_q)
                                a_data_o <= final_word;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_wb_arb2.sv
// Testbench for bram_wb_arb2. Three instances share the data stimulus, with READ_LATENCY = 1, 2, 3 and DATA_DEPTH = 1000.
// Each instance has its own cycle/strobe lines, so each one can be released on its own ack.
// Directed vectors come from a table, followed by hand-written tie, abort and mid-transaction reset sequences.
module tb_bram_wb_arb2;

    logic       clk;
    logic       rst;
    logic [9:0] a_addr, b_addr;
    logic [7:0] a_din, b_din;
    logic       a_we, b_we;
    logic       wp;
    logic [2:0] a_cyc, a_stb, b_cyc, b_stb;
    logic [2:0] a_ack, b_ack;
    logic [7:0] a_dout [3];
    logic [7:0] b_dout [3];

    int n_vec;
    int n_bad;

    int         ack_k_a [3];
    int         ack_k_b [3];
    int         ack_n_a [3];
    int         ack_n_b [3];
    logic [7:0] dat_a [3];
    logic [7:0] dat_b [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bram_wb_arb2 #(
            .DATA_WIDTH  (8),
            .DATA_DEPTH  (1000),
            .ADDR_WIDTH  (10),
            .READ_LATENCY(g + 1)
        ) dut (
            .wb_clock_i(clk),
            .wb_reset_i(rst),
            .a_addr_i  (a_addr),
            .a_data_i  (a_din),
            .a_data_o  (a_dout[g]),
            .a_we_i    (a_we),
            .a_cycle_i (a_cyc[g]),
            .a_strobe_i(a_stb[g]),
            .a_ack_o   (a_ack[g]),
            .b_addr_i  (b_addr),
            .b_data_i  (b_din),
            .b_data_o  (b_dout[g]),
            .b_we_i    (b_we),
            .b_cycle_i (b_cyc[g]),
            .b_strobe_i(b_stb[g]),
            .b_ack_o   (b_ack[g]),
            .wp_i      (wp)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         port;   // 0 = A, 1 = B
        bit         we;
        logic [9:0] addr;
        logic [7:0] data;
        bit         wp;
        logic [7:0] exp;    // data_o expected at ack (read data, or held value for a write)
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (RL=%0d): got %0d (0x%0h), expected %0d (0x%0h)", nm, d + 1, act, act, exp, exp);
        end
    endtask

    task automatic clr();
        for (int d = 0; d < 3; d++) begin
            ack_k_a[d] = -1; ack_k_b[d] = -1;
            ack_n_a[d] = 0;  ack_n_b[d] = 0;
            dat_a[d] = '0;   dat_b[d] = '0;
        end
    endtask

    // Sample n edges, #1 after each one. Like a classic master, drop a DUT's port request once that port is acked.
    task automatic run_window(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (a_ack[d]) begin
                    ack_n_a[d]++;
                    if (ack_k_a[d] < 0) begin ack_k_a[d] = k; dat_a[d] = a_dout[d]; end
                    a_cyc[d] = 1'b0; a_stb[d] = 1'b0;
                end
                if (b_ack[d]) begin
                    ack_n_b[d]++;
                    if (ack_k_b[d] < 0) begin ack_k_b[d] = k; dat_b[d] = b_dout[d]; end
                    b_cyc[d] = 1'b0; b_stb[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic req(input bit port, input bit we, input logic [9:0] addr, input logic [7:0] data);
        if (!port) begin
            a_we = we; a_addr = addr; a_din = data; a_cyc = 3'b111; a_stb = 3'b111;
        end else begin
            b_we = we; b_addr = addr; b_din = data; b_cyc = 3'b111; b_stb = 3'b111;
        end
    endtask

    // Check one port of one DUT. If exp_k < 0, that port must not ack at all.
    task automatic chk_port(input string nm, input int d, input bit port, input int exp_k, input logic [7:0] exp_dat);
        if (exp_k < 0) begin
            chk({nm, " no-ack"}, d, port ? ack_n_b[d] : ack_n_a[d], 0);
        end else begin
            chk({nm, " ack-edge"}, d, port ? ack_k_b[d] : ack_k_a[d], exp_k);
            chk({nm, " ack-count"}, d, port ? ack_n_b[d] : ack_n_a[d], 1);
            chk({nm, " data"}, d, port ? int'(dat_b[d]) : int'(dat_a[d]), int'(exp_dat));
        end
    endtask

    task automatic single(input string nm, input vec_t v);
        @(negedge clk);
        req(v.port, v.we, v.addr, v.data);
        wp = v.wp;
        @(posedge clk);
        #1;
        wp = ~v.wp;                 // wp toggles after grant and must have no effect
        clr();
        run_window(12);
        wp = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk_port(nm, d, v.port, d + 2, v.exp);
            chk_port({nm, " other"}, d, ~v.port, -1, 8'h00);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, " a_ack"}, d, int'(a_ack[d]), 0);
            chk({nm, " b_ack"}, d, int'(b_ack[d]), 0);
            chk({nm, " a_data"}, d, int'(a_dout[d]), 0);
            chk({nm, " b_data"}, d, int'(b_dout[d]), 0);
        end
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_bad = 0;
        tbl[0]  = '{0, 1, 10'h000, 8'h55, 0, 8'h00};
        tbl[1]  = '{0, 0, 10'h000, 8'h00, 0, 8'h55};
        tbl[2]  = '{0, 1, 10'h020, 8'h34, 0, 8'h55};
        tbl[3]  = '{0, 1, 10'h020, 8'h12, 1, 8'h55};   // protected write
        tbl[4]  = '{0, 0, 10'h020, 8'h00, 0, 8'h34};
        tbl[5]  = '{1, 1, 10'h3E7, 8'h66, 0, 8'h00};   // last valid word
        tbl[6]  = '{0, 1, 10'h3E8, 8'h77, 0, 8'h34};   // out of range write
        tbl[7]  = '{0, 0, 10'h3E8, 8'h00, 0, 8'h00};   // out of range read
        tbl[8]  = '{1, 0, 10'h3E7, 8'h00, 0, 8'h66};
        tbl[9]  = '{1, 1, 10'h001, 8'h5A, 0, 8'h66};
        tbl[10] = '{0, 0, 10'h001, 8'h00, 0, 8'h5A};   // cross-port read after write
        tbl[11] = '{1, 0, 10'h3FF, 8'h00, 0, 8'h00};
        tbl[12] = '{1, 0, 10'h000, 8'h00, 0, 8'h55};   // leaves last grant = B

        rst = 1'b1; wp = 1'b0;
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0; a_we = 1'b0; b_we = 1'b0;
        a_cyc = '0; a_stb = '0; b_cyc = '0; b_stb = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            single($sformatf("vec%0d", i), tbl[i]);

        // Tie with last grant = B: A is served first, then B.
        @(negedge clk);
        req(0, 1, 10'h010, 8'hAA);
        req(1, 1, 10'h011, 8'hBB);
        @(posedge clk); #1;
        clr();
        run_window(12);
        for (int d = 0; d < 3; d++) begin
            chk_port("tie1 A", d, 0, d + 2, 8'h5A);
            chk_port("tie1 B", d, 1, 2 * (d + 1) + 4, 8'h55);
        end

        v = '{0, 0, 10'h010, 8'h00, 0, 8'hAA};
        single("rd010", v);                           // last grant = A

        // Tie with last grant = A: B is served first.
        @(negedge clk);
        req(0, 0, 10'h011, 8'h00);
        req(1, 0, 10'h010, 8'h00);
        @(posedge clk); #1;
        clr();
        run_window(12);
        for (int d = 0; d < 3; d++) begin
            chk_port("tie2 B", d, 1, d + 2, 8'hAA);
            chk_port("tie2 A", d, 0, 2 * (d + 1) + 4, 8'hBB);
        end

        // Abort: cycle drops during WAIT. No ack is given, but the write still commits.
        @(negedge clk);
        req(0, 1, 10'h030, 8'h3C);
        @(posedge clk); #1;
        a_cyc = '0; a_stb = '0;
        clr();
        run_window(12);
        for (int d = 0; d < 3; d++)
            chk_port("abort", d, 0, -1, 8'h00);
        v = '{0, 0, 10'h030, 8'h00, 0, 8'h3C};
        single("rd030", v);

        // Reset during WAIT, before the access edge: no ack, and the write is lost.
        @(negedge clk);
        req(0, 1, 10'h000, 8'h99);
        @(posedge clk); #1;
        rst = 1'b1;
        a_cyc = '0; a_stb = '0;
        clr();
        run_window(3);
        chk_reset_state("mid-reset");
        rst = 1'b0;
        run_window(6);
        for (int d = 0; d < 3; d++)
            chk_port("mid-reset", d, 0, -1, 8'h00);
        v = '{0, 0, 10'h000, 8'h00, 0, 8'h55};
        single("rd000-after-reset", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
